// File: rtl/ex_muldiv_pkg.sv
// Shared types and encodings for the iterative RV32M multiply/divide unit.
package ex_muldiv_pkg;

  // Control FSM states (2-bit encoding)
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  // M-extension funct3 codes
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic md_op1_signed(input logic [2:0] op);
    logic r;
    case (op)
      MD_MULH, MD_MULHSU, MD_DIV, MD_REM: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM only
  function automatic logic md_op2_signed(input logic [2:0] op);
    logic r;
    case (op)
      MD_MULH, MD_DIV, MD_REM: r = 1'b1;
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_muldiv_abs.sv
// Conditional two's-complement negate: used to take operand magnitudes
// and to restore the sign of the final product/quotient/remainder.
module ex_muldiv_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] y_o
);

  // Negate when requested, otherwise pass through
  always_comb begin
    if (neg_i) begin
      y_o = ~a_i + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      y_o = a_i;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit. One radix-2 step per cycle
// (shift-add multiply, restoring divide) on operand magnitudes, with a
// single sign-fix cycle before the registered result is presented.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [XLEN-1:0]   op1_i,
  input  logic [XLEN-1:0]   op2_i,
  input  logic [REG_AW-1:0] rd_waddr_i,
  input  logic              flush_i,
  output logic              hold_o,
  output logic              valid_o,
  output logic [XLEN-1:0]   result_o,
  output logic [REG_AW-1:0] rd_waddr_o,
  output logic              busy_o
);

  localparam int              CNT_W     = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO_X    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] SMIN      = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [REG_AW-1:0] ZERO_REG = {REG_AW{1'b0}};

  md_state_e           state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [2:0]          op_q,     op_d;
  logic [REG_AW-1:0]   rd_q,     rd_d;
  logic [XLEN-1:0]     mag2_q,   mag2_d;
  // multiply: {high, low} product; divide: low half holds dividend/quotient
  logic [2*XLEN-1:0]   acc_q,    acc_d;
  logic [XLEN-1:0]     rem_q,    rem_d;
  logic                neg_q,    neg_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                s1_s, s2_s;
  logic [XLEN-1:0]     mag1_s, mag2_s;
  logic [XLEN:0]       mul_sum_s;
  logic [XLEN:0]       div_shift_s, div_trial_s;
  logic [2*XLEN-1:0]   fix_in_s, fix_out_s;
  logic [XLEN-1:0]     fix_res_s;
  logic                accept_s, div_zero_s, div_ovf_s;

  assign s1_s = md_op1_signed(op_i) & op1_i[XLEN-1];
  assign s2_s = md_op2_signed(op_i) & op2_i[XLEN-1];

  ex_muldiv_abs #(.WIDTH(XLEN)) u_abs_op1 (.a_i(op1_i), .neg_i(s1_s), .y_o(mag1_s));
  ex_muldiv_abs #(.WIDTH(XLEN)) u_abs_op2 (.a_i(op2_i), .neg_i(s2_s), .y_o(mag2_s));

  assign accept_s   = start_i & ~flush_i & (state_q == MD_IDLE);
  assign div_zero_s = op_i[2] & (op2_i == ZERO_X);
  assign div_ovf_s  = ((op_i == MD_DIV) | (op_i == MD_REM)) &
                      (op1_i == SMIN) & (op2_i == ALL_ONES);

  // One shift-add step: add multiplicand to the high half when the
  // current multiplier bit is set; the carry becomes the new top bit.
  assign mul_sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                     (acc_q[0] ? {1'b0, mag2_q} : {(XLEN+1){1'b0}});
  // One restoring step: shift the next dividend bit into the remainder
  // and trial-subtract the divisor; a negative trial keeps the shift.
  assign div_shift_s = {rem_q, acc_q[XLEN-1]};
  assign div_trial_s = div_shift_s - {1'b0, mag2_q};

  // Pick the magnitude to sign-fix: full product, quotient or remainder
  always_comb begin
    if (op_q[2]) begin
      fix_in_s = {ZERO_X, (op_q[1] ? rem_q : acc_q[XLEN-1:0])};
    end else begin
      fix_in_s = acc_q;
    end
  end

  ex_muldiv_abs #(.WIDTH(2*XLEN)) u_abs_fix (.a_i(fix_in_s), .neg_i(neg_q), .y_o(fix_out_s));

  // MULH* return the high half; MUL and all divides return the low half
  always_comb begin
    if (!op_q[2] && (op_q[1:0] != 2'b00)) begin
      fix_res_s = fix_out_s[2*XLEN-1:XLEN];
    end else begin
      fix_res_s = fix_out_s[XLEN-1:0];
    end
  end

  // Control FSM next state and datapath next values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    mag2_d   = mag2_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      MD_IDLE: begin
        if (accept_s) begin
          op_d   = op_i;
          rd_d   = rd_waddr_i;
          cnt_d  = CNT_ZERO;
          mag2_d = mag2_s;
          acc_d  = {ZERO_X, mag1_s};
          rem_d  = ZERO_X;
          // remainder follows the dividend; product/quotient follow s1^s2
          if (op_i[2] && op_i[1]) begin
            neg_d = s1_s;
          end else begin
            neg_d = s1_s ^ s2_s;
          end
          if (div_zero_s) begin
            state_d  = MD_DONE;
            result_d = op_i[1] ? op1_i : ALL_ONES;
          end else if (div_ovf_s) begin
            state_d  = MD_DONE;
            result_d = op_i[1] ? ZERO_X : SMIN;
          end else begin
            state_d  = MD_CALC;
          end
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_CALC: begin
        if (flush_i) begin
          state_d = MD_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          if (op_q[2]) begin
            if (!div_trial_s[XLEN]) begin
              rem_d = div_trial_s[XLEN-1:0];
              acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b1};
            end else begin
              rem_d = div_shift_s[XLEN-1:0];
              acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b0};
            end
          end else begin
            acc_d = {mul_sum_s, acc_q[XLEN-1:1]};
          end
          if (cnt_q == LAST_STEP) begin
            state_d = MD_FIX;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
      MD_FIX: begin
        if (flush_i) begin
          state_d = MD_IDLE;
        end else begin
          state_d  = MD_DONE;
          result_d = fix_res_s;
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= CNT_ZERO;
      op_q     <= MD_MUL;
      rd_q     <= ZERO_REG;
      mag2_q   <= ZERO_X;
      acc_q    <= {(2*XLEN){1'b0}};
      rem_q    <= ZERO_X;
      neg_q    <= 1'b0;
      result_q <= ZERO_X;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      mag2_q   <= mag2_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  // hold_o is combinational so the PC stalls in the request cycle itself
  assign hold_o     = accept_s | (state_q == MD_CALC) | (state_q == MD_FIX);
  assign valid_o    = (state_q == MD_DONE);
  assign busy_o     = (state_q != MD_IDLE);
  assign result_o   = result_q;
  assign rd_waddr_o = valid_o ? rd_q : ZERO_REG;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv (XLEN=32).
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [4:0]  rd_waddr_i;
  logic        flush_i;
  logic        hold_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_waddr_o;
  logic        busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  ex_muldiv #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .op1_i(op1_i), .op2_i(op2_i), .rd_waddr_i(rd_waddr_i), .flush_i(flush_i),
    .hold_o(hold_o), .valid_o(valid_o), .result_o(result_o),
    .rd_waddr_o(rd_waddr_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; drives the request in cycle 0, waits for
  // valid_o and checks latency, result, destination and hold_o profile.
  // pulse_at>0 re-pulses start_i (a DIV by zero) in that CALC cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat, input int pulse_at);
    int n;
    int holds;
    start_i = 1'b1; op_i = op; op1_i = a; op2_i = b; rd_waddr_i = rd;
    #1;
    check_eq({tag, " hold_c0"}, {31'd0, hold_o}, 32'd1);
    @(posedge clk);
    #1;
    start_i = 1'b0; op1_i = $urandom; op2_i = $urandom; rd_waddr_i = 5'($urandom);
    n = 0;
    holds = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (valid_o) break;
      if (hold_o) holds++;
      if (n == pulse_at) begin
        start_i = 1'b1; op_i = 3'b100; op1_i = 32'd9; op2_i = 32'd0;
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    check_eq({tag, " latency"}, 32'(n), 32'(exp_lat));
    check_eq({tag, " result"}, result_o, exp_res);
    check_eq({tag, " rd"}, {27'd0, rd_waddr_o}, {27'd0, rd});
    check_eq({tag, " holds"}, 32'(holds), 32'(exp_lat - 1));
    check_eq({tag, " hold_done"}, {31'd0, hold_o}, 32'd0);
    @(negedge clk);
    check_eq({tag, " strobe"}, {26'd0, valid_o, rd_waddr_o}, 32'd0);
  endtask

  initial begin
    int n;
    int vcount;
    rst = 1'b1; start_i = 1'b0; op_i = 3'b000; op1_i = 32'd0; op2_i = 32'd0;
    rd_waddr_i = 5'd0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst valid", {31'd0, valid_o}, 32'd0);
    check_eq("rst result", result_o, 32'd0);
    check_eq("rst rd", {27'd0, rd_waddr_o}, 32'd0);
    check_eq("rst busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst hold", {31'd0, hold_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 34, 0);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 34, 0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFF, 34, 0);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 34, 0);
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'hFFFF_FFFD, 34, 0);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, 34, 0);
    run_op("divu",   3'b101, 32'hFFFF_FFFE, 32'h0000_0003, 5'd9,  32'h5555_5554, 34, 0);
    run_op("remu",   3'b111, 32'd100,       32'd7,         5'd10, 32'd2,         34, 0);
    run_op("div0",   3'b100, 32'd1234,      32'd0,         5'd11, 32'hFFFF_FFFF, 1,  0);
    run_op("remu0",  3'b111, 32'h0000_1234, 32'd0,         5'd12, 32'h0000_1234, 1,  0);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1,  0);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 1,  0);
    run_op("ignore", 3'b000, 32'd2,         32'd3,         5'd15, 32'd6,         34, 5);

    // Flush a DIV in cycle 10 while start_i is pulsed in cycle 5
    start_i = 1'b1; op_i = 3'b100; op1_i = 32'd1000; op2_i = 32'd7; rd_waddr_i = 5'd16;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    vcount = 0;
    for (n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (valid_o) vcount++;
      start_i = (n == 5);
      op_i    = 3'b000;
      flush_i = (n == 10);
    end
    @(negedge clk);
    flush_i = 1'b0;
    start_i = 1'b0;
    check_eq("flush busy", {31'd0, busy_o}, 32'd0);
    check_eq("flush valid", 32'(vcount) + {31'd0, valid_o}, 32'd0);
    check_eq("flush result", result_o, 32'd6);
    run_op("after_flush", 3'b000, 32'd3, 32'd5, 5'd17, 32'd15, 34, 0);

    // Asynchronous reset in the middle of CALC
    start_i = 1'b1; op_i = 3'b000; op1_i = 32'd11; op2_i = 32'd13; rd_waddr_i = 5'd18;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst busy", {31'd0, busy_o}, 32'd0);
    check_eq("arst result", result_o, 32'd0);
    check_eq("arst hold", {31'd0, hold_o}, 32'd0);
    check_eq("arst valid_rd", {26'd0, valid_o, rd_waddr_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o) vcount++;
    end
    check_eq("arst no_valid", 32'(vcount), 32'd0);

    // start_i and flush_i together in IDLE: flush wins
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'b100; op1_i = 32'd5; op2_i = 32'd0;
    #1;
    check_eq("sf hold", {31'd0, hold_o}, 32'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    check_eq("sf busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    check_eq("sf valid", {31'd0, valid_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit, parametrised in XLEN.
- Sits beside the combinational execute stage. It takes already-selected operands plus the M-extension funct3, stalls the PC through hold_o while it iterates, and returns a registered result with the destination register address for register-file write-back.
- One radix-2 step per cycle: shift-add for multiply, restoring for divide. Sign handling is done on magnitudes.

Parameters:
- XLEN, 32, operand/result width; must be ≥ 8 and even.
- REG_AW, 5, register address width.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  request; sampled only in IDLE
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op1_i  in  XLEN  rs1 operand
- op2_i  in  XLEN  rs2 operand
- rd_waddr_i  in  REG_AW  destination register
- flush_i  in  1  abort current operation (branch/trap kill)
- hold_o  out  1  stall request to pc
- valid_o  out  1  one-cycle result strobe
- result_o  out  XLEN  result, held until next accepted start
- rd_waddr_o  out  REG_AW  destination register; zero register when valid_o=0
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, internal accumulators=0, valid_o=0, result_o=0, rd_waddr_o=0, busy_o=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start_i=1, flush_i=0: latch op, rd_waddr, operand signs and magnitudes.
  - Signed treatment per op: MULH/DIV/REM both operands signed; MULHSU op1 only; others unsigned.
  - Normal case: next state CALC, counter=0.
  - Fast path, next state DONE with result loaded directly:
    - divide by zero: DIV/DIVU → all ones; REM/REMU → op1.
    - signed overflow (op1=MIN, op2=−1): DIV → MIN; REM → 0.
- CALC: one step per cycle, counter += 1. After XLEN steps (counter==XLEN−1 at the edge) next state FIX.
  - Multiply: 2·XLEN-bit product accumulator.
  - Divide: XLEN-bit quotient, XLEN+1-bit partial remainder.
- FIX, one cycle:
  - Negate the product if sign(op1)^sign(op2) (signed ops only).
  - Negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Select low half (MUL) or high half (MULH*). Register into result_o. Next state DONE.
- DONE: valid_o=1, rd_waddr_o=latched addr. Next state IDLE unconditionally. start_i is ignored in DONE.
- Latency: start sampled in cycle 0 → valid_o in cycle XLEN+2 (normal) or cycle 1 (fast path). Next start is accepted in cycle XLEN+3 or cycle 2 respectively.
- hold_o = (start_i & state==IDLE & ~flush_i) | (state==CALC) | (state==FIX). It is combinational so the PC stalls in the request cycle; it is low in DONE so the PC advances with write-back.
- start_i in CALC/FIX/DONE: ignored; no queueing.
- flush_i in any non-IDLE state: next state IDLE, no valid_o, result_o unchanged.
- flush_i with start_i in IDLE: flush wins; nothing is accepted.
- Operand ports are don't-care after the acceptance cycle.
- rst asserted mid-CALC: immediate return to reset values; no valid_o on release.

Decomposition:
- Shared defines: MD_MUL…MD_REMU funct3 codes and MD state encodings (2 bits), next to the ALU_SEL/BR_SEL macros in defines.v. The ZERO_REG macro is reused for rd_waddr_o.
- Natural sub-module: ex_muldiv_abs, a combinational conditional two's-complement negate (width XLEN, used on inputs and in FIX).
- Control FSM and datapath stay in ex_muldiv.

Test Plan:
- MUL 7×−3 (0x00000007, 0xFFFFFFFD) → valid_o in cycle 34, result 0xFFFFFFEB; hold_o high cycles 0–33, low in 34.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MULHU same operands → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 0xFFFFFFFE/3 → 0x55555554. REMU 100/7 → 2.
- Fast paths: DIV x/0 → 0xFFFFFFFF at cycle 1. REMU 0x1234/0 → 0x1234. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM same operands → 0.
- flush_i in cycle 10 of a DIV → no valid_o, busy_o low in cycle 11. A new MUL 3×5 started in cycle 11 → 15 at cycle 45. start_i pulsed during CALC is ignored.
- rst asserted asynchronously mid-CALC → all outputs 0 immediately. start_i+flush_i together in IDLE → busy_o stays 0.
